// File: rtl/ifu_fetch_pc_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package ifu_fetch_pc_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC   = 32'h3000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Saturating event counters for fetched instructions and redirect pulses.
module ifu_perf_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetched_i,
  input  logic        flushed_i,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_flushed_o
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] fetched_q;
  logic [31:0] flushed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= sat_inc(fetched_q, fetched_i);
      flushed_q <= sat_inc(flushed_q, flushed_i);
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_flushed_o = flushed_q;

endmodule

// File: rtl/ifu_fetch_pc.sv
// Fetch-side PC sequencer: one imem request at a time, valid/ready to decode, redirect flush.
// Optional perf counters are built when IFU_PERF_EN is defined.
module ifu_fetch_pc #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ifu_fetch_pc_pkg::RESET_PC)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  input  logic            resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_misaligned,
  output logic            out_fault
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  import ifu_fetch_pc_pkg::*;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic            out_mis_q, out_mis_d;
  logic            out_fault_q, out_fault_d;
  logic            misaligned;
  logic            out_fire;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign out_fire   = (state_q == HOLD) && out_ready && !redirect_valid && !reset;

  always_ff @(posedge clock) begin
    if (reset) state_q <= REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      // A redirect in WAIT without a response still owes us one reply; DRAIN swallows it.
      case (state_q)
        WAIT:    state_d = resp_valid ? REQ : DRAIN;
        DRAIN:   state_d = DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (misaligned)     state_d = HOLD;
          else if (req_ready) state_d = WAIT;
        end
        WAIT:    if (resp_valid) state_d = HOLD;
        HOLD:    if (out_ready)  state_d = REQ;
        DRAIN:   if (resp_valid) state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  // Redirect masks the request so memory never sees a handshake that fetch treats as void.
  always_comb begin
    req_valid = (state_q == REQ) && !misaligned && !redirect_valid && !reset;
    out_valid = (state_q == HOLD) && !reset;
  end

  always_comb begin
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_mis_d   = out_mis_q;
    out_fault_d = out_fault_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (out_fire)   pc_d = pc_q + XLEN'(INST_BYTES);
    if (!redirect_valid) begin
      if ((state_q == REQ) && misaligned) begin
        out_pc_d    = pc_q;
        out_inst_d  = NOP_INST;
        out_mis_d   = 1'b1;
        out_fault_d = 1'b0;
      end else if ((state_q == WAIT) && resp_valid) begin
        out_pc_d    = pc_q;
        out_inst_d  = resp_err ? NOP_INST : resp_data;
        out_mis_d   = 1'b0;
        out_fault_d = resp_err;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_mis_q   <= 1'b0;
      out_fault_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_mis_q   <= out_mis_d;
      out_fault_q <= out_fault_d;
    end
  end

  assign req_addr       = pc_q;
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign out_misaligned = out_mis_q;
  assign out_fault      = out_fault_q;

`ifdef IFU_PERF_EN
  ifu_perf_cnt u_perf_cnt (
    .clock          (clock),
    .reset          (reset),
    .fetched_i      (out_fire),
    .flushed_i      (redirect_valid),
    .perf_fetched_o (perf_fetched),
    .perf_flushed_o (perf_flushed)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch_pc.sv
// Bench for ifu_fetch_pc: directed scenarios plus a randomized stream against a PC-sequence model.
module tb_ifu_fetch_pc;

  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misaligned;
  logic        out_fault;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  // memory model state
  int          mem_lat = 0;
  bit          mem_fixed = 1'b0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  bit          pend;
  int          cnt;
  logic [31:0] pend_addr;
  int          n_req = 0;
  int          n_fetch = 0;
  int          n_flush = 0;

  always #5 clock = ~clock;

  ifu_fetch_pc dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_misaligned (out_misaligned),
    .out_fault      (out_fault)
`ifdef IFU_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_fixed) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: one outstanding request, reply mem_lat cycles after acceptance.
  initial begin
    bit          hs;
    bit          rst_s;
    logic [31:0] addr_s;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    pend       = 1'b0;
    cnt        = 0;
    pend_addr  = '0;
    forever begin
      @(negedge clock);
      hs     = req_valid && req_ready;
      rst_s  = reset;
      addr_s = req_addr;
      @(posedge clock);
      #1;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      if (rst_s) begin
        pend = 1'b0;
      end else begin
        if (hs) begin
          pend      = 1'b1;
          cnt       = mem_lat;
          pend_addr = addr_s;
          n_req++;
        end
        if (pend) begin
          if (cnt == 0) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(pend_addr);
            resp_err   = err_en && (pend_addr == err_addr);
            pend       = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Event counts for the optional perf counters.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        n_fetch = 0;
        n_flush = 0;
      end else begin
        if (out_valid && out_ready && !redirect_valid) n_fetch++;
        if (redirect_valid) n_flush++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b0;
    out_ready      = 1'b0;
    err_en         = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b0;
    out_ready      = 1'b0;
    step();
    @(negedge clock);
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: req_valid=%b out_valid=%b, required 0 0", req_valid, out_valid);
    end
    checks++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0 || out_misaligned !== 1'b0 || out_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_outregs: pc=%h inst=%h mis=%b flt=%b, required all zero",
               out_pc, out_inst, out_misaligned, out_fault);
    end
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_first_req: req_valid=%b addr=%h, required 1 %h", req_valid, req_addr, RST_PC);
    end
    step();
  endtask

  task automatic test_stream();
    int          rq_c[$];
    logic [31:0] rq_a[$];
    int          hs_c[$];
    logic [31:0] hs_pc[$];
    logic [31:0] hs_in[$];
    do_reset();
    mem_fixed = 1'b1;
    mem_lat   = 0;
    req_ready = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (req_valid && req_ready) begin
        rq_c.push_back(c);
        rq_a.push_back(req_addr);
      end
      if (out_valid && out_ready) begin
        hs_c.push_back(c);
        hs_pc.push_back(out_pc);
        hs_in.push_back(out_inst);
      end
      step();
    end
    checks++;
    if (rq_c.size() != 4 || hs_c.size() != 4) begin
      errors++;
      $display("FAIL stream_counts: requests=%0d handshakes=%0d, required 4 4", rq_c.size(), hs_c.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rq_c[k] != 3 * k || rq_a[k] !== RST_PC + 32'(4 * k)) begin
          errors++;
          $display("FAIL stream_req%0d: cycle=%0d addr=%h, required %0d %h",
                   k, rq_c[k], rq_a[k], 3 * k, RST_PC + 32'(4 * k));
        end
        checks++;
        if (hs_c[k] != 3 * k + 2 || hs_pc[k] !== RST_PC + 32'(4 * k) || hs_in[k] !== 32'h0010_0093) begin
          errors++;
          $display("FAIL stream_out%0d: cycle=%0d pc=%h inst=%h, required %0d %h 00100093",
                   k, hs_c[k], hs_pc[k], hs_in[k], 3 * k + 2, RST_PC + 32'(4 * k));
        end
      end
    end
    out_ready = 1'b0;
    mem_fixed = 1'b0;
  endtask

  task automatic test_backpressure();
    bit          found;
    logic [31:0] pc0, in0;
    do_reset();
    mem_lat   = 0;
    req_ready = 1'b1;
    out_ready = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bp_wait_valid: out_valid=0 after 20 cycles, required 1");
      step();
      return;
    end
    pc0 = out_pc;
    in0 = out_inst;
    checks++;
    if (pc0 !== RST_PC || in0 !== mem_word(RST_PC)) begin
      errors++;
      $display("FAIL bp_first: pc=%h inst=%h, required %h %h", pc0, in0, RST_PC, mem_word(RST_PC));
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pc0 || out_inst !== in0 || req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b pc=%h inst=%h req_valid=%b, required 1 %h %h 0",
                 i, out_valid, out_pc, out_inst, req_valid, pc0, in0);
      end
      step();
      @(negedge clock);
    end
    step();
    out_ready = 1'b1;
    @(negedge clock);
    step();
    out_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== RST_PC + 32'd4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_advance: req_valid=%b addr=%h out_valid=%b, required 1 %h 0",
               req_valid, req_addr, out_valid, RST_PC + 32'd4);
    end
    step();
  endtask

  task automatic test_redirect_wait();
    bit found;
    int waited;
    do_reset();
    mem_lat   = 4;
    req_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== RST_PC) begin
      errors++;
      $display("FAIL rw_req: req_valid=%b addr=%h, required 1 %h", req_valid, req_addr, RST_PC);
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clock);
    step();
    redirect_valid = 1'b0;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (req_valid) begin
        found = 1'b1;
        break;
      end
      if (out_valid) begin
        checks++;
        errors++;
        $display("FAIL rw_no_out: out_valid=1 while draining, required 0");
      end
      waited++;
      step();
    end
    checks++;
    if (!found || waited != 4 || req_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL rw_restart: found=%b waited=%0d addr=%h, required 1 4 80000100", found, waited, req_addr);
    end
    step();
    mem_lat = 0;
    found   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found || out_pc !== 32'h8000_0100 || out_inst !== mem_word(32'h8000_0100)) begin
      errors++;
      $display("FAIL rw_first_out: found=%b pc=%h inst=%h, required 1 80000100 %h",
               found, out_pc, out_inst, mem_word(32'h8000_0100));
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_resp();
    bit          found;
    logic [31:0] rpc;
    do_reset();
    mem_lat   = 0;
    req_ready = 1'b1;
    out_ready = 1'b1;
    rpc       = $urandom & 32'hFFFF_FFFC;
    @(negedge clock);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = rpc;
    @(negedge clock);
    step();
    redirect_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== rpc || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_next_req: req_valid=%b addr=%h out_valid=%b, required 1 %h 0",
               req_valid, req_addr, out_valid, rpc);
    end
    step();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found || out_pc !== rpc || out_inst !== mem_word(rpc)) begin
      errors++;
      $display("FAIL rr_first_out: found=%b pc=%h inst=%h, required 1 %h %h",
               found, out_pc, out_inst, rpc, mem_word(rpc));
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    bit found;
    int req_snap;
    do_reset();
    mem_lat   = 0;
    req_ready = 1'b1;
    out_ready = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    step();
    req_snap       = n_req;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    out_ready      = 1'b1;
    @(negedge clock);
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    @(negedge clock);
    checks++;
    if (!found || req_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_req_cycle: found=%b req_valid=%b out_valid=%b, required 1 0 0",
               found, req_valid, out_valid);
    end
    step();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || out_misaligned !== 1'b1 || out_inst !== NOP ||
        out_pc !== 32'h8000_0102 || out_fault !== 1'b0) begin
      errors++;
      $display("FAIL mis_out: valid=%b mis=%b inst=%h pc=%h flt=%b, required 1 1 00000013 80000102 0",
               out_valid, out_misaligned, out_inst, out_pc, out_fault);
    end
    step();
    out_ready = 1'b1;
    @(negedge clock);
    step();
    out_ready = 1'b0;
    @(negedge clock);
    step();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || out_misaligned !== 1'b1 || out_pc !== 32'h8000_0106) begin
      errors++;
      $display("FAIL mis_next: valid=%b mis=%b pc=%h, required 1 1 80000106", out_valid, out_misaligned, out_pc);
    end
    checks++;
    if (n_req != req_snap) begin
      errors++;
      $display("FAIL mis_no_imem: requests=%0d, required %0d", n_req, req_snap);
    end
    step();
  endtask

  task automatic test_fault();
    int          k;
    logic [31:0] epc;
    do_reset();
    mem_lat   = 0;
    err_en    = 1'b1;
    err_addr  = RST_PC + 32'd8;
    req_ready = 1'b1;
    out_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      mem_lat = $urandom_range(0, 2);
      @(negedge clock);
      if (out_valid && out_ready) begin
        epc = RST_PC + 32'(4 * k);
        checks++;
        if (out_pc !== epc || out_fault !== (k == 2) || out_misaligned !== 1'b0 ||
            out_inst !== ((k == 2) ? NOP : mem_word(epc))) begin
          errors++;
          $display("FAIL fault_out%0d: pc=%h inst=%h flt=%b mis=%b, required %h %h %b 0",
                   k, out_pc, out_inst, out_fault, out_misaligned, epc,
                   (k == 2) ? NOP : mem_word(epc), (k == 2));
        end
        k++;
      end
      step();
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL fault_count: handshakes=%0d, required 3", k);
    end
    err_en    = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_inst, hold_pc, hold_inst, hold_addr, rpc;
    bit          prev_out_stall, prev_req_stall;
    int          since_redir, n_hs;
    do_reset();
    exp_pc         = RST_PC;
    prev_out_stall = 1'b0;
    prev_req_stall = 1'b0;
    hold_pc        = '0;
    hold_inst      = '0;
    hold_addr      = '0;
    since_redir    = 10;
    n_hs           = 0;
    for (int c = 0; c < 400; c++) begin
      req_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mem_lat   = $urandom_range(0, 3);
      since_redir++;
      if (since_redir > 6 && $urandom_range(0, 19) == 0) begin
        rpc = $urandom;
        if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        since_redir    = 0;
      end else begin
        redirect_valid = 1'b0;
      end
      @(negedge clock);
      if (prev_out_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== hold_pc || out_inst !== hold_inst) begin
          errors++;
          $display("FAIL rnd_out_stable c%0d: valid=%b pc=%h inst=%h, required 1 %h %h",
                   c, out_valid, out_pc, out_inst, hold_pc, hold_inst);
        end
      end
      if (prev_req_stall) begin
        checks++;
        if (req_addr !== hold_addr || (!redirect_valid && req_valid !== 1'b1)) begin
          errors++;
          $display("FAIL rnd_req_stable c%0d: valid=%b addr=%h, required 1 %h", c, req_valid, req_addr, hold_addr);
        end
      end
      if (req_valid && req_ready) begin
        checks++;
        if (req_addr !== exp_pc || exp_pc[1:0] != 2'b00) begin
          errors++;
          $display("FAIL rnd_req_addr c%0d: addr=%h, required %h (aligned)", c, req_addr, exp_pc);
        end
      end
      if (out_valid && out_ready && !redirect_valid) begin
        exp_inst = (exp_pc[1:0] != 2'b00) ? NOP : mem_word(exp_pc);
        checks++;
        if (out_pc !== exp_pc || out_inst !== exp_inst || out_fault !== 1'b0 ||
            out_misaligned !== (exp_pc[1:0] != 2'b00)) begin
          errors++;
          $display("FAIL rnd_out c%0d: pc=%h inst=%h mis=%b flt=%b, required %h %h %b 0",
                   c, out_pc, out_inst, out_misaligned, out_fault, exp_pc, exp_inst, (exp_pc[1:0] != 2'b00));
        end
        exp_pc = exp_pc + 32'd4;
        n_hs++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_out_stall = out_valid && !out_ready && !redirect_valid;
      hold_pc        = out_pc;
      hold_inst      = out_inst;
      prev_req_stall = req_valid && !req_ready;
      hold_addr      = req_addr;
      step();
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    checks++;
    if (n_hs < 20) begin
      errors++;
      $display("FAIL rnd_progress: handshakes=%0d, required at least 20", n_hs);
    end
  endtask

`ifdef IFU_PERF_EN
  task automatic test_perf();
    checks++;
    if (perf_fetched !== 32'(n_fetch) || perf_flushed !== 32'(n_flush)) begin
      errors++;
      $display("FAIL perf_counts: fetched=%0d flushed=%0d, required %0d %0d",
               perf_fetched, perf_flushed, n_fetch, n_flush);
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b0;
    out_ready      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_misaligned();
    test_fault();
    test_random();
`ifdef IFU_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
